// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer (00:00-99:59) with debounced active-low keys,
// active-low 7-segment digit outputs and a self-clearing alarm.
module countdown_timer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int ALARM_SEC  = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_START,
  input  logic       KEY_MIN,
  input  logic       KEY_SEC,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       BUZZ,
  output logic       RUN_LED
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYCLES - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  // Time is packed as {M1, M0, S1, S0}, one BCD nibble each.
  function automatic logic [7:0] inc_bcd2(input logic [7:0] v, input logic [3:0] tens_max);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == tens_max) r[7:4] = 4'd0;
      else                    r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d, input logic [3:0] max_d);
    logic [6:0] s;
    if (d > max_d) begin
      s = 7'b111_1111;
    end else begin
      case (d)
        4'd0:    s = 7'b100_0000;
        4'd1:    s = 7'b111_1001;
        4'd2:    s = 7'b010_0100;
        4'd3:    s = 7'b011_0000;
        4'd4:    s = 7'b001_1001;
        4'd5:    s = 7'b001_0010;
        4'd6:    s = 7'b000_0010;
        4'd7:    s = 7'b111_1000;
        4'd8:    s = 7'b000_0000;
        4'd9:    s = 7'b001_0000;
        default: s = 7'b111_1111;
      endcase
    end
    return s;
  endfunction

  // Key index 0 = START, 1 = MIN, 2 = SEC; levels are active-low.
  logic [2:0]    key_raw_s;
  logic [2:0]    sync1_r, sync2_r, deb_r, press_r;
  logic [DW-1:0] deb_cnt_r [3];
  logic          start_p_s, min_p_s, sec_p_s;

  assign key_raw_s = {KEY_SEC, KEY_MIN, KEY_START};

  // Synchronize each key, accept a new level after it is stable, flag presses
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      deb_r   <= 3'b111;
      press_r <= 3'b000;
      for (int i = 0; i < 3; i++) deb_cnt_r[i] <= '0;
    end else begin
      sync1_r <= key_raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 3; i++) begin
        press_r[i] <= 1'b0;
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= '0;
        end else if (deb_cnt_r[i] == DEB_MAX) begin
          deb_r[i]     <= sync2_r[i];
          deb_cnt_r[i] <= '0;
          press_r[i]   <= ~sync2_r[i];
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  assign start_p_s = press_r[0];
  assign min_p_s   = press_r[1] & ~press_r[0];
  assign sec_p_s   = press_r[2] & ~press_r[1] & ~press_r[0];

  state_t        state_r, state_nx;
  logic [15:0]   time_r, time_nx, dec_s;
  logic [PW-1:0] presc_r, presc_nx;
  logic [AW-1:0] alarm_cnt_r, alarm_nx;
  logic          tick_s, buzz_r, run_led_r;

  // Next state, time, prescaler and alarm count
  always_comb begin
    state_nx = state_r;
    time_nx  = time_r;
    alarm_nx = alarm_cnt_r;
    presc_nx = '0;
    tick_s   = 1'b0;
    dec_s    = dec_time(time_r);
    if (state_r == ST_RUN || state_r == ST_ALARM) begin
      if (presc_r == PRESC_MAX) begin
        tick_s   = 1'b1;
        presc_nx = '0;
      end else begin
        presc_nx = presc_r + PW'(1);
      end
    end else begin
      presc_nx = '0;
    end
    case (state_r)
      ST_IDLE: begin
        if (start_p_s) begin
          if (time_r != 16'h0000) state_nx = ST_RUN;
          else                    state_nx = ST_IDLE;
        end else if (min_p_s) begin
          time_nx[15:8] = inc_bcd2(time_r[15:8], 4'd9);
        end else if (sec_p_s) begin
          time_nx[7:0] = inc_bcd2(time_r[7:0], 4'd5);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A pause request takes precedence over a coincident tick.
        if (start_p_s) begin
          state_nx = ST_PAUSE;
        end else if (tick_s) begin
          time_nx = dec_s;
          if (dec_s == 16'h0000) begin
            state_nx = ST_ALARM;
            alarm_nx = '0;
          end else begin
            state_nx = ST_RUN;
          end
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (start_p_s) begin
          state_nx = ST_RUN;
        end else if (min_p_s) begin
          time_nx  = 16'h0000;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (press_r != 3'b000) begin
          state_nx = ST_IDLE;
        end else if (tick_s) begin
          if (alarm_cnt_r == ALARM_LAST) state_nx = ST_IDLE;
          else                           alarm_nx = alarm_cnt_r + AW'(1);
        end else begin
          state_nx = ST_ALARM;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, time, prescaler, alarm count and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      time_r      <= 16'h0000;
      presc_r     <= '0;
      alarm_cnt_r <= '0;
      buzz_r      <= 1'b0;
      run_led_r   <= 1'b0;
    end else begin
      state_r     <= state_nx;
      time_r      <= time_nx;
      presc_r     <= presc_nx;
      alarm_cnt_r <= alarm_nx;
      buzz_r      <= (state_nx == ST_ALARM);
      run_led_r   <= (state_nx == ST_RUN);
    end
  end

  assign BUZZ    = buzz_r;
  assign RUN_LED = run_led_r;
  assign HEX0    = seg7(time_r[3:0],   4'd9);
  assign HEX1    = seg7(time_r[7:4],   4'd5);
  assign HEX2    = seg7(time_r[11:8],  4'd9);
  assign HEX3    = seg7(time_r[15:12], 4'd9);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed plus randomized bench for countdown_timer; expectations come from a
// seconds-based model of the timer and a digit-to-segment table.
module tb_countdown_timer;
  localparam int CLK_HZ     = 10;
  localparam int DEB_CYCLES = 2;
  localparam int ALARM_SEC  = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       KEY_START = 1'b1;
  logic       KEY_MIN = 1'b1;
  logic       KEY_SEC = 1'b1;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       BUZZ, RUN_LED;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int n = 0;
  logic [6:0] seg_tab [10];

  countdown_timer #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB_CYCLES), .ALARM_SEC(ALARM_SEC)) dut (
    .CLK(CLK), .RST(RST), .KEY_START(KEY_START), .KEY_MIN(KEY_MIN), .KEY_SEC(KEY_SEC),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .BUZZ(BUZZ), .RUN_LED(RUN_LED)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input int m, input int s);
    check({tag, ".hex0"}, 32'(HEX0), 32'(seg_tab[s % 10]));
    check({tag, ".hex1"}, 32'(HEX1), 32'(seg_tab[s / 10]));
    check({tag, ".hex2"}, 32'(HEX2), 32'(seg_tab[m % 10]));
    check({tag, ".hex3"}, 32'(HEX3), 32'(seg_tab[m / 10]));
  endtask

  task automatic check_total(input string tag, input int total);
    check_disp(tag, total / 60, total % 60);
  endtask

  task automatic set_key(input int which, input logic v);
    case (which)
      0:       KEY_START = v;
      1:       KEY_MIN = v;
      default: KEY_SEC = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_key(which, 1'b0);
    step(hold);
    set_key(which, 1'b1);
    step(8);
  endtask

  // which_sig 0 = RUN_LED, 1 = BUZZ; an expired bound fails the final check.
  task automatic wait_level(input string tag, input int which_sig, input logic lvl,
                            input int bound, output int cnt);
    cnt = 0;
    while (((which_sig == 0) ? RUN_LED : BUZZ) !== lvl && cnt < bound) begin
      step(1);
      cnt++;
    end
    check(tag, 32'((which_sig == 0) ? RUN_LED : BUZZ), 32'(lvl));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    step(1);
  endtask

  initial begin
    int nm, ns, mm, ss, total, k;
    seg_tab[0] = 7'b100_0000; seg_tab[1] = 7'b111_1001; seg_tab[2] = 7'b010_0100;
    seg_tab[3] = 7'b011_0000; seg_tab[4] = 7'b001_1001; seg_tab[5] = 7'b001_0010;
    seg_tab[6] = 7'b000_0010; seg_tab[7] = 7'b111_1000; seg_tab[8] = 7'b000_0000;
    seg_tab[9] = 7'b001_0000;

    step(3);
    RST = 1'b0;
    step(1);
    check("rst.hex0", 32'(HEX0), 32'h40);
    check("rst.hex3", 32'(HEX3), 32'h40);
    check("rst.buzz", 32'(BUZZ), 32'd0);
    check("rst.run", 32'(RUN_LED), 32'd0);

    // Setting: wraps, glitch rejection, held key
    repeat (61) press(2, 6);
    check_disp("sec_wrap", 0, 1);
    repeat (101) press(1, 6);
    check_disp("min_wrap", 1, 1);
    KEY_SEC = 1'b0;
    step(1);
    KEY_SEC = 1'b1;
    step(10);
    check_disp("glitch", 1, 1);
    KEY_MIN = 1'b0;
    step(50);
    KEY_MIN = 1'b1;
    step(8);
    check_disp("held", 2, 1);

    // Countdown with borrow from 01:00, then alarm timeout
    do_reset();
    press(1, 6);
    check_disp("set_0100", 1, 0);
    KEY_START = 1'b0;
    wait_level("run_rise", 0, 1'b1, 20, lat);
    KEY_START = 1'b1;
    check("key_latency", 32'(lat >= 3 && lat <= DEB_CYCLES + 4), 32'd1);
    step(CLK_HZ - 1);
    check_disp("pre_tick", 1, 0);
    step(1);
    check_disp("first_tick", 0, 59);
    check("first_tick.hex1_lit", 32'(HEX1), 32'(7'b001_0010));
    check("first_tick.hex0_lit", 32'(HEX0), 32'(7'b001_0000));
    step(59 * CLK_HZ - 1);
    check_total("last_sec", 1);
    check("last_sec.buzz", 32'(BUZZ), 32'd0);
    step(1);
    check_total("zero", 0);
    check("zero.buzz", 32'(BUZZ), 32'd1);
    check("zero.run", 32'(RUN_LED), 32'd0);
    step(ALARM_SEC * CLK_HZ - 1);
    check("alarm_hold.buzz", 32'(BUZZ), 32'd1);
    step(1);
    check("alarm_end.buzz", 32'(BUZZ), 32'd0);
    check("alarm_end.run", 32'(RUN_LED), 32'd0);
    step(30);
    check_total("idle_after_alarm", 0);

    // Alarm cut short by a SEC press
    press(2, 6);
    check_total("set_0001", 1);
    KEY_START = 1'b0;
    wait_level("run2_rise", 0, 1'b1, 20, n);
    KEY_START = 1'b1;
    step(CLK_HZ);
    check("alarm2.buzz", 32'(BUZZ), 32'd1);
    step(10);
    KEY_SEC = 1'b0;
    wait_level("sec_exit", 1, 1'b0, 20, n);
    check("sec_exit_latency", 32'(n), 32'(lat));
    KEY_SEC = 1'b1;
    step(10);
    check_total("after_sec_exit", 0);
    check("after_sec_exit.run", 32'(RUN_LED), 32'd0);

    // Pause coinciding with the first tick, resume, pause, clear
    do_reset();
    repeat (5) press(2, 6);
    check_total("set_0005", 5);
    KEY_START = 1'b0;
    wait_level("run3_rise", 0, 1'b1, 20, n);
    KEY_START = 1'b1;
    check("run3_latency", 32'(n), 32'(lat));
    step(CLK_HZ - lat);
    KEY_START = 1'b0;
    step(lat);
    KEY_START = 1'b1;
    check("pause_on_tick.run", 32'(RUN_LED), 32'd0);
    check_total("pause_on_tick", 5);
    step(20);
    check_total("paused_hold", 5);
    KEY_START = 1'b0;
    wait_level("resume_rise", 0, 1'b1, 20, n);
    KEY_START = 1'b1;
    step(CLK_HZ - 1);
    check_total("resume_pre", 5);
    step(1);
    check_total("resume_tick", 4);
    KEY_START = 1'b0;
    wait_level("pause2_fall", 0, 1'b0, 20, n);
    KEY_START = 1'b1;
    step(8);
    check_total("paused2", 4);
    press(1, 6);
    check_total("pause_clear", 0);
    check("pause_clear.run", 32'(RUN_LED), 32'd0);
    press(0, 6);
    step(10);
    check("start_at_zero.run", 32'(RUN_LED), 32'd0);

    // START and MIN pressed together in IDLE
    repeat (3) press(2, 6);
    KEY_START = 1'b0;
    KEY_MIN = 1'b0;
    step(6);
    KEY_START = 1'b1;
    KEY_MIN = 1'b1;
    step(4);
    check("start_min.run", 32'(RUN_LED), 32'd1);
    check_total("start_min", 3);

    // Reset while running
    RST = 1'b1;
    step(2);
    check("midrun_rst.hex0", 32'(HEX0), 32'h40);
    check("midrun_rst.hex1", 32'(HEX1), 32'h40);
    check("midrun_rst.hex2", 32'(HEX2), 32'h40);
    check("midrun_rst.hex3", 32'(HEX3), 32'h40);
    check("midrun_rst.buzz", 32'(BUZZ), 32'd0);
    check("midrun_rst.run", 32'(RUN_LED), 32'd0);
    RST = 1'b0;
    step(20);
    check("post_rst.run", 32'(RUN_LED), 32'd0);
    check_total("post_rst", 0);

    // Randomized set-and-run against the seconds model
    for (int it = 0; it < 4; it++) begin
      do_reset();
      nm = int'($urandom_range(0, 3));
      ns = int'($urandom_range(1, 75));
      repeat (nm) press(1, int'($urandom_range(4, 10)));
      repeat (ns) press(2, int'($urandom_range(4, 10)));
      mm = nm % 100;
      ss = ns % 60;
      check_disp("rand_set", mm, ss);
      total = mm * 60 + ss;
      if (total > 0) begin
        KEY_START = 1'b0;
        wait_level("rand_run_rise", 0, 1'b1, 20, n);
        KEY_START = 1'b1;
        k = int'($urandom_range(0, CLK_HZ * ((total < 4) ? total : 4) - 1));
        step(k);
        check_total("rand_run", total - k / CLK_HZ);
        check("rand_run.run", 32'(RUN_LED), 32'd1);
      end else begin
        press(0, 6);
        check("rand_zero.run", 32'(RUN_LED), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Minutes:seconds countdown timer, the down-counting counterpart of the 00–59 second counter.
- Three active-low push keys set, start and pause the time; display range is 00:00–99:59.
- Drives four active-low 7-segment digits and a buzzer/alarm output.
- Sits at board top level beside the up-counter display blocks and shares the same segment encoding.

Parameters:
- CLK_HZ, 50_000_000: clock cycles per 1 s tick.
- DEB_CYCLES, 1_000_000: cycles a synchronized key level must stay stable before it is accepted (20 ms at 50 MHz).
- ALARM_SEC, 5: number of 1 s ticks the alarm stays on before auto-return to IDLE.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- KEY_START  in  1  start/pause key, active-low, asynchronous to CLK.
- KEY_MIN  in  1  minutes key, active-low, asynchronous.
- KEY_SEC  in  1  seconds key, active-low, asynchronous.
- HEX0  out  7  seconds ones digit, gfedcba, 0 = segment lit.
- HEX1  out  7  seconds tens digit.
- HEX2  out  7  minutes ones digit.
- HEX3  out  7  minutes tens digit.
- BUZZ  out  1  high while in ALARM.
- RUN_LED  out  1  high while in RUN.

Behaviour:
- Reset:
  - Synchronous, active-high; it overrides everything, including mid-run and mid-alarm.
  - Clears all four BCD digits to 0, state to IDLE, prescaler, debouncers and alarm counter.
  - Outputs after reset: HEX0–HEX3 = 7'b100_0000, BUZZ = 0, RUN_LED = 0.
- Key front end, per key:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level updates only after the synchronized level has been unchanged for DEB_CYCLES consecutive cycles.
  - A press pulse is exactly 1 cycle wide, on the debounced released→pressed transition.
  - Pulse appears at most DEB_CYCLES+3 cycles after a clean key fall.
  - A held key gives one pulse only; glitches shorter than DEB_CYCLES give none.
- Same-cycle pulse priority: START > MIN > SEC. Lower-priority pulses in that cycle are discarded.
- Time state: four BCD digits S0 (0–9), S1 (0–5), M0 (0–9), M1 (0–9).
- Digit decode:
  - Combinational from the digit registers, same table as the existing 0–9 decoder.
  - An out-of-range digit is unreachable and decodes to all segments off (7'b111_1111).
- Prescaler: counts 0..CLK_HZ-1; tick is 1 cycle when the count equals CLK_HZ-1. It is cleared in every cycle where the state is not RUN or ALARM.
- States:
  - IDLE:
    - SEC pulse: seconds +1, 59→00 wrap, no carry into minutes.
    - MIN pulse: minutes +1, 99→00 wrap.
    - START pulse: go to RUN if time ≠ 00:00; ignored at 00:00.
  - RUN (RUN_LED = 1):
    - First tick occurs exactly CLK_HZ cycles after the START pulse cycle.
    - On tick, decrement by one second with BCD borrow: S0 0→9 borrows S1; S1 0→5 borrows M0; M0 0→9 borrows M1.
    - If the decremented value is 00:00, go to ALARM on the same edge and clear the alarm counter.
    - START pulse: go to PAUSE. If a tick coincides with it, pause wins and no decrement occurs.
    - MIN and SEC pulses are ignored.
  - PAUSE:
    - Digits are held.
    - START pulse: go to RUN, prescaler restarts from 0.
    - MIN pulse: clear time to 00:00 and go to IDLE.
    - SEC pulse: ignored.
  - ALARM (BUZZ = 1):
    - Display shows 00:00.
    - Alarm counter increments on each tick; after the ALARM_SEC-th tick, go to IDLE.
    - Any key pulse: go to IDLE immediately.
- Outputs:
  - BUZZ and RUN_LED are registered state decodes; they change on the same edge as the state.
  - HEX outputs follow the digit registers with zero added latency.

Test Plan:
- Reset/decode: assert RST 2 cycles mid-RUN → state IDLE; HEX0–3 = 7'b100_0000; BUZZ = 0; RUN_LED = 0.
- Setting (CLK_HZ=10, DEB_CYCLES=2):
  - 61 SEC presses → seconds wrap to 01, minutes stay 00.
  - 101 MIN presses → minutes = 01.
  - 1-cycle key glitch → no change.
  - Key held 50 cycles → exactly one increment.
- Countdown with borrow: set 01:00, START → after 10 cycles display 00:59 (HEX1 = 7'b001_0010, HEX0 = 7'b001_0000); after 590 more cycles display 00:00, BUZZ = 1 on that edge.
- Alarm exit:
  - No keys → BUZZ falls exactly ALARM_SEC×CLK_HZ cycles after rising, state IDLE.
  - Repeat with a SEC press mid-alarm → BUZZ falls one cycle after the pulse.
- Pause/resume/clear:
  - Set 00:05, START, pulse START in the same cycle as a tick → display stays 00:05, RUN_LED = 0.
  - START again → 00:04 after exactly 10 cycles.
  - Pause, then MIN → 00:00 in IDLE.
- START at 00:00 in IDLE → ignored (RUN_LED stays 0). START and MIN pulses in the same cycle in IDLE → START wins, minutes unchanged.
